// File: rtl/pe_lane_mac_pkg.sv
// Shared state encoding and width helpers for the pe_lane_mac lane-parallel MAC.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pe_state_e;

  function automatic int pe_clog2(input int n);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits when only one value is needed.
  function automatic int pe_width(input int n);
    return (pe_clog2(n) == 0) ? 1 : pe_clog2(n);
  endfunction

endpackage

// File: rtl/pe_lane_mac_adder_tree.sv
// Combinational sum of LANES signed W x W products, sign-extended to ACC_WIDTH.
module pe_lane_adder_tree #(
  parameter int W         = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 23
) (
  input  logic [LANES*W-1:0]          a_flat,
  input  logic [LANES*W-1:0]          b_flat,
  output logic signed [ACC_WIDTH-1:0] sum
);

  logic signed [2*W-1:0] prod;

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod = $signed(a_flat[i*W +: W]) * $signed(b_flat[i*W +: W]);
      sum  = sum + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/pe_lane_mac.sv
// Lane-parallel dot product plus bias: LANES products per cycle, IDLE/RUN/HOLD handshake.
// Optional macro PE_LANE_RELU_EN clamps negative results to zero.
module pe_lane_mac
  import pe_pkg::*;
#(
  parameter int VECTOR_LENGTH = 64,
  parameter int W             = 8,
  parameter int LANES         = 4,
  parameter int ACC_WIDTH     = 2*W + pe_clog2(VECTOR_LENGTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W*VECTOR_LENGTH-1:0]    in_vector_flat,
  input  logic [W*VECTOR_LENGTH-1:0]    weight_row_flat,
  input  logic signed [W-1:0]           bias,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_WIDTH-1:0]   result
);

  localparam int BEATS  = VECTOR_LENGTH / LANES;
  localparam int BEAT_W = pe_width(BEATS);
  localparam int SLICE  = LANES * W;

  if (VECTOR_LENGTH % LANES != 0) begin : g_bad_lanes
    $error("pe_lane_mac: VECTOR_LENGTH must be a multiple of LANES");
  end

  pe_state_e                   state, state_n;
  logic [W*VECTOR_LENGTH-1:0]  x_q, w_q;
  logic signed [W-1:0]         bias_q;
  logic signed [ACC_WIDTH-1:0] acc, lane_sum, acc_next, final_sum, result_d;
  logic [BEAT_W-1:0]           beat;
  logic                        accept, last_beat;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (state == RUN) && (beat == BEAT_W'(BEATS - 1));

  // Operand registers shift down one slice per beat, so the lanes always read the low slice.
  pe_lane_adder_tree #(
    .W         (W),
    .LANES     (LANES),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_tree (
    .a_flat (x_q[SLICE-1:0]),
    .b_flat (w_q[SLICE-1:0]),
    .sum    (lane_sum)
  );

  always_comb begin
    acc_next  = acc + lane_sum;
    final_sum = acc_next + ACC_WIDTH'(bias_q);
`ifdef PE_LANE_RELU_EN
    result_d  = final_sum[ACC_WIDTH-1] ? '0 : final_sum;
`else
    result_d  = final_sum;
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)    state_n = RUN;
      RUN:     if (last_beat) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      w_q    <= '0;
      bias_q <= '0;
      acc    <= '0;
      beat   <= '0;
      result <= '0;
    end else if (accept) begin
      x_q    <= in_vector_flat;
      w_q    <= weight_row_flat;
      bias_q <= bias;
      acc    <= '0;
      beat   <= '0;
    end else if (state == RUN) begin
      x_q  <= x_q >> SLICE;
      w_q  <= w_q >> SLICE;
      acc  <= acc_next;
      beat <= beat + 1'b1;
      if (last_beat) result <= result_d;
    end
  end

endmodule

// File: tb/tb_pe_lane_mac.sv
// Directed bench for pe_lane_mac with an expected-result queue; honours PE_LANE_RELU_EN.
module tb_pe_lane_mac;

  localparam int VL  = 64;
  localparam int W   = 8;
  localparam int LN  = 4;
  localparam int ACC = 2*W + 6 + 1;
  localparam int LAT = VL / LN;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [W*VL-1:0]       in_vector_flat = '0;
  logic [W*VL-1:0]       weight_row_flat = '0;
  logic signed [W-1:0]   bias = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic signed [ACC-1:0] result;

  int     n_assert = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     acc_cyc = 0;
  int     xa[VL];
  int     wa[VL];
  int     bv;
  longint exp_q[$];
  longint held;

  pe_lane_mac #(
    .VECTOR_LENGTH (VL),
    .W             (W),
    .LANES         (LN)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_vector_flat  (in_vector_flat),
    .weight_row_flat (weight_row_flat),
    .bias            (bias),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .result          (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint model();
    longint s = 0;
    for (int i = 0; i < VL; i++) s += longint'(xa[i]) * longint'(wa[i]);
    s += longint'(bv);
`ifdef PE_LANE_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic drive_operands();
    for (int i = 0; i < VL; i++) begin
      in_vector_flat[i*W +: W]  = xa[i][W-1:0];
      weight_row_flat[i*W +: W] = wa[i][W-1:0];
    end
    bias = bv[W-1:0];
  endtask

  task automatic fill_random();
    for (int i = 0; i < VL; i++) begin
      xa[i] = int'($urandom_range(255)) - 128;
      wa[i] = int'($urandom_range(255)) - 128;
    end
    bv = int'($urandom_range(255)) - 128;
  endtask

  task automatic start_job();
    for (int n = 0; n < 200 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_before_accept", longint'(in_ready), 1);
    drive_operands();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
    exp_q.push_back(model());
    chk("in_ready_in_run", longint'(in_ready), 0);
  endtask

  task automatic wait_result(input string tag);
    for (int n = 0; n < 200 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_out_valid"}, longint'(out_valid), 1);
    chk({tag, "_latency"}, longint'(cyc - acc_cyc), LAT);
    if (out_valid && exp_q.size() > 0) chk({tag, "_result"}, longint'(result), exp_q.pop_front());
  endtask

  task automatic retire(input string tag);
    held = longint'(result);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_idle_result_held"}, longint'(result), held);
  endtask

  initial begin
    int seen;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_result", longint'(result), 0);
    reset = 1'b0;

    for (int i = 0; i < VL; i++) begin xa[i] = 1; wa[i] = 1; end
    bv = 0;
    start_job();
    wait_result("ones");
    retire("ones");

    for (int i = 0; i < VL; i++) begin xa[i] = -128; wa[i] = -128; end
    bv = -128;
    start_job();
    wait_result("max_mag");
    retire("max_mag");

    for (int i = 0; i < VL; i++) begin xa[i] = i; wa[i] = -1; end
    bv = 5;
    start_job();
    wait_result("negative");
    retire("negative");

    // Stall in HOLD while inputs toggle and in_valid is offered.
    fill_random();
    start_job();
    for (int n = 0; n < 200 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("stall_out_valid", longint'(out_valid), 1);
    held = exp_q.pop_front();
    for (int k = 0; k < 10; k++) begin
      in_vector_flat  = ~in_vector_flat;
      weight_row_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom};
      bias = ~bias;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("stall_result", longint'(result), held);
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_hold", longint'(out_valid), 1);
    end
    in_valid = 1'b0;
    retire("stall");
    chk("stall_in_ready_after", longint'(in_ready), 1);

    fill_random();
    start_job();
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_in_ready", longint'(in_ready), 1);
    chk("abort_result", longint'(result), 0);
    chk("abort_out_valid", longint'(out_valid), 0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_out_valid", longint'(seen), 0);

    out_ready = 1'b1;
    fill_random();
    start_job();
    for (int j = 0; j < 3; j++) begin
      wait_result("b2b");
      fill_random();
      drive_operands();
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_idle_gap_in_ready", longint'(in_ready), 1);
      chk("b2b_idle_gap_out_valid", longint'(out_valid), 0);
      start_job();
    end
    wait_result("b2b_last");
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("scoreboard_empty", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_lane_mac.md
PE_LANE_MAC -- requirements
Module: pe_lane_mac

Interface
REQ-001 Parameter VECTOR_LENGTH, default 64, element count of one dot product.
REQ-002 Parameter W, default 8, signed element/bias width.
REQ-003 Parameter LANES, default 4, products summed per cycle; VECTOR_LENGTH % LANES != 0 SHALL be an elaboration error.
REQ-004 Parameter ACC_WIDTH, default 2*W+clog2(VECTOR_LENGTH)+1, signed accumulator/result width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operand set offered.
REQ-008 in_ready  output  1  block accepts operands.
REQ-009 in_vector_flat  input  W*VECTOR_LENGTH  signed elements; element i at [i*W +: W].
REQ-010 weight_row_flat  input  W*VECTOR_LENGTH  signed weights, same packing.
REQ-011 bias  input  W  signed bias.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 result  output  ACC_WIDTH  signed dot product plus bias.

Function
REQ-015 States IDLE, RUN, HOLD; IDLE->RUN on in_valid&&in_ready; RUN->HOLD after last beat; HOLD->IDLE on out_valid&&out_ready.
REQ-016 in_ready = (state==IDLE); out_valid = (state==HOLD); both combinational from state.
REQ-017 On accept, vectors and bias SHALL be registered; later input changes SHALL not affect the result.
REQ-018 On accept, accumulator and beat counter SHALL clear to 0.
REQ-019 RUN beat b (0..VECTOR_LENGTH/LANES-1) SHALL add the sum of LANES sign-extended products of elements b*LANES..b*LANES+LANES-1.
REQ-020 On final beat, result SHALL register acc + beat sum + sign-extended bias; no intermediate overflow for any legal inputs.
REQ-021 Latency: out_valid high exactly VECTOR_LENGTH/LANES cycles after the accept edge; LANES==VECTOR_LENGTH gives 1 cycle.
REQ-022 result SHALL stay stable while out_valid high and out_ready low.
REQ-023 in_valid during RUN/HOLD SHALL be ignored (no accept, no state change).
REQ-024 result SHALL hold last value after HOLD->IDLE until next final beat.

Reset
REQ-025 reset SHALL force IDLE, acc=0, beat counter=0, result=0, out_valid=0, in_ready=1 on next edge.
REQ-026 reset asserted mid-RUN or in HOLD SHALL abandon the operation; no out_valid for it.
REQ-027 reset SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro PE_LANE_RELU_EN defined: result written as 0 when final sum negative, else the sum.
REQ-029 Macro PE_LANE_RELU_EN undefined: result SHALL be the signed sum, negatives passed through.

Structure
REQ-030 Package pe_pkg SHALL hold state enumeration (IDLE/RUN/HOLD) and the clog2-based width helper.
REQ-031 Sub-module pe_lane_adder_tree SHALL compute the combinational sum of LANES signed products at ACC_WIDTH.

Verification
REQ-032 LANES=4, VECTOR_LENGTH=64, all x=1, w=1, bias=0 -> result 64, out_valid 16 cycles after accept.
REQ-033 All x=-128, w=-128, bias=-128 -> result 64*16384-128=1048448, no overflow.
REQ-034 x[i]=i, w=-1, bias=5, macro undefined -> -2011; macro defined -> 0.
REQ-035 out_ready low 10 cycles in HOLD, inputs toggled -> result stable, in_ready low, second in_valid ignored.
REQ-036 reset at beat 7 of RUN -> next cycle IDLE, result=0, out_valid never asserted for that job.
REQ-037 Back-to-back jobs, out_ready tied high -> each result correct, one idle cycle between HOLD and next accept.
